commit_multi: RTL and testbench
===============================

Name: commit_multi

Overview:
- Parametrised N-wide in-order retirement unit for the out-of-order core. Sits between the ROB head window and the architectural regfile, the store queue and the front-end redirect path.
- Each cycle it retires up to COMMIT_WIDTH consecutive ready head entries and enables regfile writes.
- It gates store retirement on a store-queue handshake.
- On a committed mispredicted control-flow instruction it runs a registered, multi-cycle flush sequence.
- It keeps a 64-bit retired-instruction counter.

Parameters:
- COMMIT_WIDTH, 2, number of ROB head slots examined and retireable per cycle (1..4).
- FLUSH_CYCLES, 2, cycles flush_o stays asserted after a mispredict commit (>=1).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- head_valid  in  COMMIT_WIDTH  slot i holds a valid ROB entry (slot 0 = oldest).
- head_ready  in  COMMIT_WIDTH  slot i result complete.
- head_opcode  in  COMMIT_WIDTH*7  RV32I opcode per slot.
- head_rd  in  COMMIT_WIDTH*5  destination register per slot.
- head_mispredict  in  COMMIT_WIDTH  slot i is a resolved control-flow op with wrong prediction.
- head_target_pc  in  COMMIT_WIDTH*32  correct next PC per slot.
- sq_commit_ready  in  1  store queue can accept a store retirement this cycle.
- sq_commit_valid  out  1  a store retires this cycle.
- rob_pop_count  out  $clog2(COMMIT_WIDTH+1)  entries popped from ROB head this cycle.
- regfile_we  out  COMMIT_WIDTH  per-slot architectural write enable.
- flush_o  out  1  pipeline flush (registered).
- redirect_pc_o  out  32  fetch redirect target, valid with flush_o (registered).
- instret_o  out  64  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN; flush_o=0; redirect_pc_o=0; instret_o=0; flush counter=0.
  - Combinational outputs evaluate to 0 while state!=RUN.
- States:
  - RUN: commits allowed.
  - FLUSH: no commits; flush_o=1.
- Commit eligibility in RUN. Slot i commits iff all of the following hold:
  - slots 0..i-1 commit;
  - head_valid[i] && head_ready[i];
  - no earlier slot in this cycle is a store or a mispredict;
  - if slot i is a store (opcode == store_opcode), sq_commit_ready=1.
- Group termination:
  - A store terminates the group. At most one store retires per cycle.
  - A store with sq_commit_ready=0 does not commit; it and all younger slots stall.
- rob_pop_count = number of committing slots; they are always a contiguous prefix from slot 0.
- regfile_we[i] = committing && opcode not in {store_opcode, br_opcode} && head_rd[i] != 0.
- sq_commit_valid = 1 iff a store slot commits.
- Mispredict:
  - A committing slot with head_mispredict=1 is the last committed slot of the group. Its regfile write still happens (jal/jalr link).
  - Next edge: state -> FLUSH; flush_o=1; redirect_pc_o = that slot's head_target_pc; counter = FLUSH_CYCLES-1.
- FLUSH:
  - Counter decrements each cycle; at 0, next edge returns to RUN and flush_o=0.
  - flush_o is therefore high exactly FLUSH_CYCLES cycles.
  - rob_pop_count=0, regfile_we=0, sq_commit_valid=0 throughout.
  - Head inputs are ignored.
- instret_o increments by rob_pop_count each edge and wraps modulo 2^64.
- Simultaneous cases:
  - Store and mispredict in one group: whichever is older terminates the group; the younger does not commit.
  - Mispredict on slot 0 with slot 1 ready: pop_count=1.
- Invalid older slot: head_valid[i]=0 blocks all slots >i, even if ready.
- Reset during FLUSH: immediate return to RUN, flush_o=0.
- Latency:
  - Commit decisions are same-cycle (combinational from head inputs).
  - Flush and redirect appear one cycle after the mispredict commit.

Decomposition:
- rv32i_types package: store_opcode, br_opcode (existing), plus new commit_state_t enum {RUN, FLUSH}.
- A COMMIT_WIDTH-dependent count width localparam also lives in the package.
- One natural sub-module, commit_select: a pure combinational prefix-eligibility chain producing the commit mask, pop count and store/mispredict selection.
- The parent holds the FSM, flush counter, redirect register and instret.

Test Plan:
- Width 2, both slots valid/ready ALU ops rd=5,6 -> pop_count=2, regfile_we=2'b11, instret +2.
- Slot0 ALU rd=0, slot1 br_opcode -> pop_count=2, regfile_we=2'b00.
- Slot0 store with sq_commit_ready=0, slot1 ready ALU -> pop_count=0, sq_commit_valid=0. Then ready=1 -> pop_count=1, sq_commit_valid=1.
- Slot0 br mispredict target 0x8000_0040, slot1 ready -> pop_count=1 that cycle. Next cycle flush_o=1 and redirect_pc_o=0x8000_0040 for exactly 2 cycles, pop_count=0 throughout, then RUN.
- Slot0 valid=0, slot1 valid/ready -> pop_count=0.
- Assert rst_n=0 mid-FLUSH -> flush_o=0 and instret_o=0 immediately. After release, normal commits resume.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I opcode constants and commit-stage types for the retirement unit.
package rv32i_types;

   localparam logic [6:0] store_opcode = 7'b0100011;
   localparam logic [6:0] br_opcode    = 7'b1100011;

   localparam int COMMIT_WIDTH_DEF = 2;
   localparam int COMMIT_CNT_W     = $clog2(COMMIT_WIDTH_DEF + 1);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } commit_state_t;

endpackage

// File: rtl/commit_select.sv
// Prefix-eligibility chain over the ROB head window: picks the contiguous group
// of slots that retire this cycle and reports store / mispredict selection.
module commit_select
   import rv32i_types::*;
#(
   parameter int COMMIT_WIDTH = 2,
   parameter int CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
   input  logic                      en,
   input  logic [COMMIT_WIDTH-1:0]   head_valid,
   input  logic [COMMIT_WIDTH-1:0]   head_ready,
   input  logic [COMMIT_WIDTH*7-1:0] head_opcode,
   input  logic [COMMIT_WIDTH*5-1:0] head_rd,
   input  logic [COMMIT_WIDTH-1:0]   head_mispredict,
   input  logic [COMMIT_WIDTH*32-1:0] head_target_pc,
   input  logic                      sq_commit_ready,
   output logic [COMMIT_WIDTH-1:0]   commit_mask,
   output logic [COMMIT_WIDTH-1:0]   we_mask,
   output logic [CNT_W-1:0]          pop_count,
   output logic                      store_commit,
   output logic                      mp_commit,
   output logic [31:0]               mp_target
);

   logic       blocked;
   logic       is_store;
   logic       is_br;
   logic [6:0] op;

   always_comb begin
      commit_mask  = '0;
      we_mask      = '0;
      pop_count    = '0;
      store_commit = 1'b0;
      mp_commit    = 1'b0;
      mp_target    = 32'h0;
      blocked      = ~en;
      is_store     = 1'b0;
      is_br        = 1'b0;
      op           = 7'h0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         op       = head_opcode[i*7 +: 7];
         is_store = (op == store_opcode);
         is_br    = (op == br_opcode);
         if (!blocked && head_valid[i] && head_ready[i] && (!is_store || sq_commit_ready)) begin
            commit_mask[i] = 1'b1;
            pop_count      = pop_count + CNT_W'(1);
            we_mask[i]     = !is_store && !is_br && (head_rd[i*5 +: 5] != 5'd0);
            // Stores and mispredicts both close the group; the mispredict's own
            // write still lands so jal/jalr links are preserved.
            if (is_store) begin
               store_commit = 1'b1;
               blocked      = 1'b1;
            end
            if (head_mispredict[i]) begin
               mp_commit = 1'b1;
               mp_target = head_target_pc[i*32 +: 32];
               blocked   = 1'b1;
            end
         end else begin
            blocked = 1'b1;
         end
      end
   end

endmodule

// File: rtl/commit_multi.sv
// N-wide in-order retirement unit: commit FSM, registered flush/redirect
// sequence and the 64-bit retired-instruction counter.
//
//  state | meaning
//  RUN   | head group evaluated and retired each cycle
//  FLUSH | flush_o high, no retirement, counting down FLUSH_CYCLES
module commit_multi
   import rv32i_types::*;
#(
   parameter int COMMIT_WIDTH = 2,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [COMMIT_WIDTH-1:0]             head_valid,
   input  logic [COMMIT_WIDTH-1:0]             head_ready,
   input  logic [COMMIT_WIDTH*7-1:0]           head_opcode,
   input  logic [COMMIT_WIDTH*5-1:0]           head_rd,
   input  logic [COMMIT_WIDTH-1:0]             head_mispredict,
   input  logic [COMMIT_WIDTH*32-1:0]          head_target_pc,
   input  logic                                sq_commit_ready,
   output logic                                sq_commit_valid,
   output logic [$clog2(COMMIT_WIDTH+1)-1:0]   rob_pop_count,
   output logic [COMMIT_WIDTH-1:0]             regfile_we,
   output logic                                flush_o,
   output logic [31:0]                         redirect_pc_o,
   output logic [63:0]                         instret_o
);

   localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);
   localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   commit_state_t    state_q, state_d;
   logic [FC_W-1:0]  fcnt_q, fcnt_d;
   logic [31:0]      redirect_q, redirect_d;
   logic [63:0]      instret_q, instret_d;

   logic [COMMIT_WIDTH-1:0] commit_mask;
   logic [COMMIT_WIDTH-1:0] we_mask;
   logic [CNT_W-1:0]        pop_count;
   logic                    store_commit;
   logic                    mp_commit;
   logic [31:0]             mp_target;

   commit_select #(
      .COMMIT_WIDTH (COMMIT_WIDTH),
      .CNT_W        (CNT_W)
   ) u_select (
      .en              (state_q == RUN),
      .head_valid      (head_valid),
      .head_ready      (head_ready),
      .head_opcode     (head_opcode),
      .head_rd         (head_rd),
      .head_mispredict (head_mispredict),
      .head_target_pc  (head_target_pc),
      .sq_commit_ready (sq_commit_ready),
      .commit_mask     (commit_mask),
      .we_mask         (we_mask),
      .pop_count       (pop_count),
      .store_commit    (store_commit),
      .mp_commit       (mp_commit),
      .mp_target       (mp_target)
   );

   always_comb begin
      state_d    = state_q;
      fcnt_d     = fcnt_q;
      redirect_d = redirect_q;
      instret_d  = instret_q + 64'(pop_count);
      case (state_q)
         RUN: begin
            if (mp_commit) begin
               state_d    = FLUSH;
               fcnt_d     = FC_W'(FLUSH_CYCLES - 1);
               redirect_d = mp_target;
            end
         end
         FLUSH: begin
            if (fcnt_q == '0) begin
               state_d = RUN;
            end else begin
               fcnt_d = fcnt_q - FC_W'(1);
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         fcnt_q     <= '0;
         redirect_q <= 32'h0;
         instret_q  <= 64'h0;
      end else begin
         state_q    <= state_d;
         fcnt_q     <= fcnt_d;
         redirect_q <= redirect_d;
         instret_q  <= instret_d;
      end
   end

   logic unused_mask;
   assign unused_mask = ^commit_mask;

   assign sq_commit_valid = store_commit;
   assign rob_pop_count   = pop_count;
   assign regfile_we      = we_mask;
   assign flush_o         = (state_q == FLUSH);
   assign redirect_pc_o   = redirect_q;
   assign instret_o       = instret_q;

endmodule

// File: tb/tb_commit_multi.sv
// Directed bench for commit_multi at COMMIT_WIDTH=2, FLUSH_CYCLES=2.
module tb_commit_multi;

   localparam logic [6:0] OP_ALU = 7'b0110011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  head_valid;
   logic [1:0]  head_ready;
   logic [13:0] head_opcode;
   logic [9:0]  head_rd;
   logic [1:0]  head_mispredict;
   logic [63:0] head_target_pc;
   logic        sq_commit_ready;
   logic        sq_commit_valid;
   logic [1:0]  rob_pop_count;
   logic [1:0]  regfile_we;
   logic        flush_o;
   logic [31:0] redirect_pc_o;
   logic [63:0] instret_o;

   int n_tests = 0;
   int n_fail  = 0;

   commit_multi #(.COMMIT_WIDTH(2), .FLUSH_CYCLES(2)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .head_valid      (head_valid),
      .head_ready      (head_ready),
      .head_opcode     (head_opcode),
      .head_rd         (head_rd),
      .head_mispredict (head_mispredict),
      .head_target_pc  (head_target_pc),
      .sq_commit_ready (sq_commit_ready),
      .sq_commit_valid (sq_commit_valid),
      .rob_pop_count   (rob_pop_count),
      .regfile_we      (regfile_we),
      .flush_o         (flush_o),
      .redirect_pc_o   (redirect_pc_o),
      .instret_o       (instret_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic slots(input logic [1:0] v, input logic [1:0] r,
                        input logic [6:0] op0, input logic [4:0] rd0,
                        input logic [6:0] op1, input logic [4:0] rd1,
                        input logic [1:0] mp, input logic [31:0] tgt0,
                        input logic sqr);
      head_valid      = v;
      head_ready      = r;
      head_opcode     = {op1, op0};
      head_rd         = {rd1, rd0};
      head_mispredict = mp;
      head_target_pc  = {32'h1111_0000, tgt0};
      sq_commit_ready = sqr;
      #1;
   endtask

   task automatic comb(input string tag, input logic [1:0] pop, input logic [1:0] we, input logic sqv);
      check({tag, ".pop"}, 64'(rob_pop_count), 64'(pop));
      check({tag, ".we"},  64'(regfile_we),    64'(we));
      check({tag, ".sqv"}, 64'(sq_commit_valid), 64'(sqv));
   endtask

   initial begin
      rst_n = 1'b0;
      slots(2'b00, 2'b00, OP_ALU, 5'd0, OP_ALU, 5'd0, 2'b00, 32'h0, 1'b0);
      #12;
      check("rst.flush",    64'(flush_o), 64'd0);
      check("rst.redirect", 64'(redirect_pc_o), 64'd0);
      check("rst.instret",  instret_o, 64'd0);
      comb("rst", 2'd0, 2'b00, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // two ALU ops
      slots(2'b11, 2'b11, OP_ALU, 5'd5, OP_ALU, 5'd6, 2'b00, 32'h0, 1'b0);
      comb("alu2", 2'd2, 2'b11, 1'b0);
      tick();
      check("alu2.instret", instret_o, 64'd2);

      // rd=0 and branch: retire without writes
      slots(2'b11, 2'b11, OP_ALU, 5'd0, OP_BR, 5'd9, 2'b00, 32'h0, 1'b0);
      comb("rd0br", 2'd2, 2'b00, 1'b0);
      tick();
      check("rd0br.instret", instret_o, 64'd4);

      // store stalled, then accepted (terminates group)
      slots(2'b11, 2'b11, OP_ST, 5'd3, OP_ALU, 5'd4, 2'b00, 32'h0, 1'b0);
      comb("ststall", 2'd0, 2'b00, 1'b0);
      tick();
      check("ststall.instret", instret_o, 64'd4);
      slots(2'b11, 2'b11, OP_ST, 5'd3, OP_ALU, 5'd4, 2'b00, 32'h0, 1'b1);
      comb("stgo", 2'd1, 2'b00, 1'b1);
      tick();
      check("stgo.instret", instret_o, 64'd5);

      // invalid oldest slot blocks younger ready slot
      slots(2'b10, 2'b11, OP_ALU, 5'd1, OP_ALU, 5'd2, 2'b00, 32'h0, 1'b1);
      comb("inv0", 2'd0, 2'b00, 1'b0);
      tick();
      check("inv0.instret", instret_o, 64'd5);

      // ALU then store in slot 1
      slots(2'b11, 2'b11, OP_ALU, 5'd3, OP_ST, 5'd0, 2'b00, 32'h0, 1'b1);
      comb("alust", 2'd2, 2'b01, 1'b1);
      tick();
      check("alust.instret", instret_o, 64'd7);

      // mispredict on slot 0, slot 1 ready
      slots(2'b11, 2'b11, OP_BR, 5'd0, OP_ALU, 5'd7, 2'b01, 32'h8000_0040, 1'b1);
      comb("mp", 2'd1, 2'b00, 1'b0);
      check("mp.flush_pre", 64'(flush_o), 64'd0);
      tick();
      check("mp.instret", instret_o, 64'd8);
      check("fl1.flush", 64'(flush_o), 64'd1);
      check("fl1.redirect", 64'(redirect_pc_o), 64'h8000_0040);
      comb("fl1", 2'd0, 2'b00, 1'b0);
      tick();
      check("fl2.flush", 64'(flush_o), 64'd1);
      check("fl2.redirect", 64'(redirect_pc_o), 64'h8000_0040);
      comb("fl2", 2'd0, 2'b00, 1'b0);
      check("fl2.instret", instret_o, 64'd8);
      slots(2'b11, 2'b11, OP_ALU, 5'd5, OP_ALU, 5'd6, 2'b00, 32'h0, 1'b0);
      comb("fl2b", 2'd0, 2'b00, 1'b0);
      tick();
      check("run.flush", 64'(flush_o), 64'd0);
      comb("run", 2'd2, 2'b11, 1'b0);
      tick();
      check("run.instret", instret_o, 64'd10);

      // jal mispredict keeps its link write, then reset mid-flush
      slots(2'b11, 2'b11, OP_JAL, 5'd1, OP_ALU, 5'd2, 2'b01, 32'h0000_1234, 1'b0);
      comb("jal", 2'd1, 2'b01, 1'b0);
      tick();
      check("jal.instret", instret_o, 64'd11);
      check("jal.flush", 64'(flush_o), 64'd1);
      check("jal.redirect", 64'(redirect_pc_o), 64'h1234);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstfl.flush", 64'(flush_o), 64'd0);
      check("rstfl.instret", instret_o, 64'd0);
      check("rstfl.redirect", 64'(redirect_pc_o), 64'd0);
      #1;
      rst_n = 1'b1;
      slots(2'b11, 2'b11, OP_ALU, 5'd5, OP_ALU, 5'd6, 2'b00, 32'h0, 1'b0);
      comb("post", 2'd2, 2'b11, 1'b0);
      tick();
      check("post.instret", instret_o, 64'd2);
      check("post.flush", 64'(flush_o), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
